// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester streams and UART port shared by the arbiter and its neighbours
interface uart_tx_arbiter_if;
  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req0_last;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic       req1_last;
  logic       req1_ready;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [1:0] grant;
  logic       arb_busy;

  modport slave (
    input  req0_valid, req0_data, req0_last,
    input  req1_valid, req1_data, req1_last,
    input  tx_busy,
    output req0_ready, req1_ready,
    output tx_start, tx_data, grant, arb_busy
  );

  modport master (
    output req0_valid, req0_data, req0_last,
    output req1_valid, req1_data, req1_last,
    output tx_busy,
    input  req0_ready, req1_ready,
    input  tx_start, tx_data, grant, arb_busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-level round-robin arbiter pacing one UART transmitter
module uart_tx_arbiter #(
  parameter int INTER_BYTE_DELAY = 1000,
  parameter int BUSY_TIMEOUT     = 16
) (
  input  logic             clk,
  input  logic             resetN,
  uart_tx_arbiter_if.slave bus
);
  localparam int GAP_CYCLES = (INTER_BYTE_DELAY < 1) ? 1 : INTER_BYTE_DELAY;
  localparam int GW         = $clog2(GAP_CYCLES + 1);
  localparam int BT         = (BUSY_TIMEOUT < 1) ? 1 : BUSY_TIMEOUT;
  localparam int BW         = $clog2(BT + 1);

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE, GAP} state_t;

  state_t          state, state_nxt;
  logic [1:0]      grant_q;
  logic            last_owner;
  logic            last_flag;
  logic [7:0]      tx_data_q;
  logic [BW-1:0]   busy_cnt;
  logic [GW-1:0]   gap_cnt;
  logic [1:0]      pick;
  logic            ready0, ready1, xfer;
  logic            busy_timeout, gap_done;

  assign ready0       = (state == LOAD) && grant_q[0] && bus.req0_valid;
  assign ready1       = (state == LOAD) && grant_q[1] && bus.req1_valid;
  assign xfer         = ready0 || ready1;
  assign busy_timeout = (busy_cnt == BW'(BT - 1));
  assign gap_done     = (gap_cnt <= GW'(1));

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.tx_start   = (state == START);
  assign bus.tx_data    = tx_data_q;
  assign bus.grant      = grant_q;
  assign bus.arb_busy   = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!resetN) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pick      = 2'b00;
    // On contention the requester that did not own the previous packet wins.
    if (bus.req0_valid && bus.req1_valid) pick = last_owner ? 2'b01 : 2'b10;
    else                                  pick = {bus.req1_valid, bus.req0_valid};
    case (state)
      IDLE:      if (pick != 2'b00) state_nxt = LOAD;
      LOAD:      if (xfer) state_nxt = START;
      START:     state_nxt = WAIT_BUSY;
      WAIT_BUSY: if (bus.tx_busy || busy_timeout) state_nxt = WAIT_DONE;
      WAIT_DONE: if (!bus.tx_busy) state_nxt = GAP;
      GAP:       if (gap_done) state_nxt = last_flag ? IDLE : LOAD;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      grant_q    <= 2'b00;
      last_owner <= 1'b1;
      last_flag  <= 1'b0;
      tx_data_q  <= 8'h00;
      busy_cnt   <= '0;
      gap_cnt    <= '0;
    end else begin
      case (state)
        IDLE: grant_q <= pick;
        LOAD: begin
          if (xfer) begin
            tx_data_q <= grant_q[0] ? bus.req0_data : bus.req1_data;
            last_flag <= grant_q[0] ? bus.req0_last : bus.req1_last;
          end
        end
        START: busy_cnt <= '0;
        WAIT_BUSY: begin
          if (busy_cnt != BW'(BT)) busy_cnt <= busy_cnt + BW'(1);
        end
        WAIT_DONE: begin
          if (!bus.tx_busy) gap_cnt <= GW'(GAP_CYCLES);
        end
        GAP: begin
          // Down-counter stops at its last step, so it never wraps.
          if (gap_done) begin
            if (last_flag) begin
              last_owner <= grant_q[1];
              grant_q    <= 2'b00;
            end
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed bench for uart_tx_arbiter with a 20-cycle busy UART model
module tb_uart_tx_arbiter;
  logic clk;
  logic resetN;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  bit   model_en = 1'b1;

  logic       pend;
  int         bcnt;
  int         start_cyc[$];
  logic [7:0] start_data[$];
  logic [1:0] grant_trace[$];
  int         r1_seen;

  uart_tx_arbiter_if bus ();

  uart_tx_arbiter #(.INTER_BYTE_DELAY(4), .BUSY_TIMEOUT(16)) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // UART model: busy rises one idle cycle after the start pulse and stays high 20 cycles.
  always @(posedge clk) begin
    if (!resetN) begin
      pend        <= 1'b0;
      bcnt        <= 0;
      bus.tx_busy <= 1'b0;
    end else begin
      pend <= bus.tx_start && model_en;
      if (pend) begin
        bcnt        <= 20;
        bus.tx_busy <= 1'b1;
      end else if (bcnt > 1) begin
        bcnt <= bcnt - 1;
      end else if (bcnt == 1) begin
        bcnt        <= 0;
        bus.tx_busy <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (bus.tx_start) begin
      start_cyc.push_back(cyc);
      start_data.push_back(bus.tx_data);
    end
    grant_trace.push_back(bus.grant);
    if (bus.req1_ready) r1_seen++;
  end

  task automatic clear_log();
    start_cyc.delete();
    start_data.delete();
    grant_trace.delete();
    r1_seen = 0;
  endtask

  task automatic set_req(input int r, input logic v, input logic [7:0] d, input logic l);
    if (r == 0) begin
      bus.req0_valid = v; bus.req0_data = d; bus.req0_last = l;
    end else begin
      bus.req1_valid = v; bus.req1_data = d; bus.req1_last = l;
    end
  endtask

  task automatic send_byte(input int r, input logic [7:0] d, input logic l);
    int n = 0;
    set_req(r, 1'b1, d, l);
    #1;
    while (!((r == 0) ? bus.req0_ready : bus.req1_ready) && n < 2000) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 2000) begin
      compared++; mismatched++;
      $display("FAIL send_byte_timeout: req%0d byte %h never got ready, required ready within 2000 cycles", r, d);
    end else begin
      @(posedge clk);
    end
    @(negedge clk);
    set_req(r, 1'b0, d, l);
  endtask

  task automatic send_pkt(input int r, input int n, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    for (int i = 0; i < n; i++)
      send_byte(r, (i == 0) ? b0 : (i == 1) ? b1 : b2, (i == n - 1));
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetN = 1'b0;
    set_req(0, 1'b0, 8'h00, 1'b0);
    set_req(1, 1'b0, 8'h00, 1'b0);
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    clear_log();
  endtask

  task automatic wait_done(input int nbytes, input int budget, output int end_cyc);
    int n = 0;
    while (!(start_data.size() >= nbytes && !bus.arb_busy) && n < budget) begin
      @(negedge clk); #1; n++;
    end
    end_cyc = cyc;
    if (n >= budget) begin
      compared++; mismatched++;
      $display("FAIL wait_done_timeout: %0d bytes seen arb_busy=%b, required %0d bytes and idle within %0d cycles",
               start_data.size(), bus.arb_busy, nbytes, budget);
    end
  endtask

  // IDLE cycles between the last req0-owned cycle and the first req1-owned cycle; -1 if no handover.
  function automatic int idle_gap();
    int last0 = -1;
    int z = 0;
    for (int i = 0; i < grant_trace.size(); i++)
      if (grant_trace[i] == 2'b01) last0 = i;
    if (last0 < 0) return -1;
    for (int i = last0 + 1; i < grant_trace.size(); i++) begin
      if (grant_trace[i] == 2'b00) z++;
      else if (grant_trace[i] == 2'b10) return z;
      else return -1;
    end
    return -1;
  endfunction

  task automatic test_reset();
    @(negedge clk);
    resetN = 1'b0;
    set_req(0, 1'b1, 8'h5C, 1'b1);
    set_req(1, 1'b1, 8'hC5, 1'b1);
    @(negedge clk);
    compared += 6;
    if (bus.arb_busy !== 1'b0)   begin mismatched++; $display("FAIL reset_arb_busy: got %b need 0", bus.arb_busy); end
    if (bus.grant !== 2'b00)     begin mismatched++; $display("FAIL reset_grant: got %b need 00", bus.grant); end
    if (bus.tx_start !== 1'b0)   begin mismatched++; $display("FAIL reset_tx_start: got %b need 0", bus.tx_start); end
    if (bus.tx_data !== 8'h00)   begin mismatched++; $display("FAIL reset_tx_data: got %h need 00", bus.tx_data); end
    if (bus.req0_ready !== 1'b0) begin mismatched++; $display("FAIL reset_req0_ready: got %b need 0", bus.req0_ready); end
    if (bus.req1_ready !== 1'b0) begin mismatched++; $display("FAIL reset_req1_ready: got %b need 0", bus.req1_ready); end
    do_reset();
  endtask

  task automatic test_single_packet();
    int t0, t_end, n01, n10;
    do_reset();
    t0 = cyc;
    fork send_pkt(0, 2, 8'h31, 8'h0A, 8'h00); join_none
    wait_done(2, 300, t_end);
    n01 = 0; n10 = 0;
    foreach (grant_trace[i]) begin
      if (grant_trace[i] == 2'b01) n01++;
      if (grant_trace[i] == 2'b10) n10++;
    end
    compared += 9;
    if (start_data.size() != 2) begin mismatched++; $display("FAIL single_count: got %0d starts need 2", start_data.size()); end
    if (start_data[0] !== 8'h31) begin mismatched++; $display("FAIL single_byte0: got %h need 31", start_data[0]); end
    if (start_data[1] !== 8'h0A) begin mismatched++; $display("FAIL single_byte1: got %h need 0a", start_data[1]); end
    if (start_cyc[0] - t0 != 2)  begin mismatched++; $display("FAIL single_latency: got %0d need 2", start_cyc[0] - t0); end
    if (start_cyc[1] - start_cyc[0] != 28) begin mismatched++; $display("FAIL single_byte_period: got %0d need 28", start_cyc[1] - start_cyc[0]); end
    if (t_end - start_cyc[1] != 27) begin mismatched++; $display("FAIL single_tail: got %0d need 27", t_end - start_cyc[1]); end
    if (n01 != 56 || n10 != 0) begin mismatched++; $display("FAIL single_grant_cycles: got 01x%0d 10x%0d need 01x56 10x0", n01, n10); end
    if (r1_seen != 0) begin mismatched++; $display("FAIL single_req1_ready: got %0d cycles need 0", r1_seen); end
    if (bus.grant !== 2'b00) begin mismatched++; $display("FAIL single_grant_end: got %b need 00", bus.grant); end
  endtask

  task automatic test_contention();
    int t_end, g;
    do_reset();
    for (int round = 0; round < 2; round++) begin
      clear_log();
      fork
        send_pkt(0, 1, 8'hAA, 8'h00, 8'h00);
        send_pkt(1, 1, 8'h55, 8'h00, 8'h00);
      join_none
      wait_done(2, 300, t_end);
      g = idle_gap();
      compared += 4;
      if (start_data.size() != 2) begin mismatched++; $display("FAIL contention_count r%0d: got %0d need 2", round, start_data.size()); end
      if (start_data[0] !== 8'hAA) begin mismatched++; $display("FAIL contention_first r%0d: got %h need aa", round, start_data[0]); end
      if (start_data[1] !== 8'h55) begin mismatched++; $display("FAIL contention_second r%0d: got %h need 55", round, start_data[1]); end
      if (g != 1) begin mismatched++; $display("FAIL contention_idle_gap r%0d: got %0d need 1", round, g); end
    end
  endtask

  task automatic test_back_to_back();
    int t_end, g;
    do_reset();
    fork
      send_pkt(0, 3, 8'h10, 8'h20, 8'h30);
      begin repeat (8) @(negedge clk); send_pkt(1, 1, 8'hC3, 8'h00, 8'h00); end
    join_none
    wait_done(4, 400, t_end);
    g = idle_gap();
    compared += 5;
    if (start_data.size() != 4) begin mismatched++; $display("FAIL b2b_count: got %0d need 4", start_data.size()); end
    if (start_data[0] !== 8'h10 || start_data[1] !== 8'h20 || start_data[2] !== 8'h30)
      begin mismatched++; $display("FAIL b2b_req0_bytes: got %h %h %h need 10 20 30", start_data[0], start_data[1], start_data[2]); end
    if (start_data[3] !== 8'hC3) begin mismatched++; $display("FAIL b2b_req1_byte: got %h need c3", start_data[3]); end
    if (start_cyc[2] - start_cyc[0] != 56) begin mismatched++; $display("FAIL b2b_contiguous: got %0d need 56", start_cyc[2] - start_cyc[0]); end
    if (g != 1) begin mismatched++; $display("FAIL b2b_idle_gap: got %0d need 1", g); end
  endtask

  task automatic test_busy_timeout();
    int t_end;
    model_en = 1'b0;
    do_reset();
    fork send_pkt(0, 1, 8'h77, 8'h00, 8'h00); join_none
    wait_done(1, 200, t_end);
    compared += 3;
    if (start_data.size() != 1) begin mismatched++; $display("FAIL timeout_count: got %0d need 1", start_data.size()); end
    if (t_end - start_cyc[0] != 22) begin mismatched++; $display("FAIL timeout_release: got %0d need 22", t_end - start_cyc[0]); end
    if (bus.arb_busy !== 1'b0) begin mismatched++; $display("FAIL timeout_arb_busy: got %b need 0", bus.arb_busy); end
    model_en = 1'b1;
  endtask

  task automatic test_reset_mid_packet();
    int late_start, late_grant;
    do_reset();
    send_byte(0, 8'h11, 1'b0);
    send_byte(0, 8'h22, 1'b0);
    repeat (4) @(negedge clk);
    compared += 1;
    if (bus.arb_busy !== 1'b1 || bus.grant !== 2'b01)
      begin mismatched++; $display("FAIL midreset_pre: got busy=%b grant=%b need 1 01", bus.arb_busy, bus.grant); end
    resetN = 1'b0;
    @(negedge clk);
    resetN = 1'b1;
    compared += 4;
    if (bus.arb_busy !== 1'b0) begin mismatched++; $display("FAIL midreset_idle: got %b need 0", bus.arb_busy); end
    if (bus.grant !== 2'b00)   begin mismatched++; $display("FAIL midreset_grant: got %b need 00", bus.grant); end
    if (bus.tx_start !== 1'b0) begin mismatched++; $display("FAIL midreset_tx_start: got %b need 0", bus.tx_start); end
    if (bus.tx_data !== 8'h00) begin mismatched++; $display("FAIL midreset_tx_data: got %h need 00", bus.tx_data); end
    late_start = 0; late_grant = 0;
    repeat (60) begin
      @(negedge clk);
      if (bus.tx_start) late_start++;
      if (bus.grant != 2'b00) late_grant++;
    end
    compared += 2;
    if (late_start != 0) begin mismatched++; $display("FAIL midreset_no_more_bytes: got %0d starts need 0", late_start); end
    if (late_grant != 0) begin mismatched++; $display("FAIL midreset_no_grant: got %0d cycles need 0", late_grant); end
  endtask

  task automatic test_valid_stall();
    int t_end, g;
    do_reset();
    send_byte(0, 8'hA1, 1'b0);
    fork begin repeat (3) @(negedge clk); send_pkt(1, 1, 8'h5A, 8'h00, 8'h00); end join_none
    repeat (30) @(negedge clk);
    compared += 4;
    if (bus.grant !== 2'b01)     begin mismatched++; $display("FAIL stall_grant: got %b need 01", bus.grant); end
    if (bus.arb_busy !== 1'b1)   begin mismatched++; $display("FAIL stall_arb_busy: got %b need 1", bus.arb_busy); end
    if (bus.req0_ready !== 1'b0) begin mismatched++; $display("FAIL stall_req0_ready: got %b need 0", bus.req0_ready); end
    if (bus.req1_ready !== 1'b0) begin mismatched++; $display("FAIL stall_req1_ready: got %b need 0", bus.req1_ready); end
    repeat (7) @(negedge clk);
    send_byte(0, 8'hA2, 1'b1);
    wait_done(3, 300, t_end);
    g = idle_gap();
    compared += 4;
    if (start_data.size() != 3) begin mismatched++; $display("FAIL stall_count: got %0d need 3", start_data.size()); end
    if (start_data[0] !== 8'hA1 || start_data[1] !== 8'hA2 || start_data[2] !== 8'h5A)
      begin mismatched++; $display("FAIL stall_order: got %h %h %h need a1 a2 5a", start_data[0], start_data[1], start_data[2]); end
    if (start_cyc[1] - start_cyc[0] != 38) begin mismatched++; $display("FAIL stall_byte_spacing: got %0d need 38", start_cyc[1] - start_cyc[0]); end
    if (g != 1) begin mismatched++; $display("FAIL stall_idle_gap: got %0d need 1", g); end
  endtask

  initial begin
    resetN = 1'b0;
    set_req(0, 1'b0, 8'h00, 1'b0);
    set_req(1, 1'b0, 8'h00, 1'b0);
    r1_seen = 0;
    repeat (2) @(negedge clk);
    test_reset();
    test_single_packet();
    test_contention();
    test_back_to_back();
    test_busy_timeout();
    test_reset_mid_packet();
    test_valid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
